// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-slave SPI master that frames a 10-bit command on MOSI
// under SS_n and, for read-data commands, collects an 8-bit response from MISO.
module spi_master_ctrl #(
   parameter int unsigned RD_WAIT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [9:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned FRAME_W = 10;
   localparam int unsigned BYTE_W  = 8;

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(BYTE_W - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = (RD_WAIT == 0) ? CNT_W'(0) : CNT_W'(RD_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_CMD,
      S_SHIFT,
      S_HOLD,
      S_WAIT,
      S_RECV,
      S_END
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [BYTE_W-1:0]   rx_q, rx_d;
   logic [BYTE_W-1:0]   rd_data_q, rd_data_d;
   logic                ss_n_q, ss_n_d;
   logic                mosi_q, mosi_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_valid_q, rd_valid_d;
   logic                is_rd_data;

   assign is_rd_data = (frame_q[9:8] == 2'b11);

   // Next state, shared counter and datapath; outputs derived from the next state so they are registered
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      frame_d    = frame_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      ss_n_d     = 1'b1;
      mosi_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rd_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               frame_d = cmd_data;
               state_d = S_SELECT;
               cnt_d   = '0;
            end
         end
         S_SELECT: begin
            state_d = S_CMD;
            cnt_d   = '0;
         end
         S_CMD: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            cnt_d = '0;
            if (is_rd_data) begin
               state_d = (RD_WAIT == 0) ? S_RECV : S_WAIT;
            end else begin
               state_d = S_END;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_RECV;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RECV: begin
            rx_d = {rx_q[BYTE_W-2:0], MISO};
            if (cnt_q == RECV_LAST) begin
               rd_data_d = {rx_q[BYTE_W-2:0], MISO};
               state_d   = S_END;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_END: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      ss_n_d = (state_d == S_IDLE) || (state_d == S_END);
      if (state_d == S_END) begin
         done_d     = 1'b1;
         rd_valid_d = is_rd_data;
      end
      if (state_d == S_CMD) begin
         mosi_d = frame_q[FRAME_W-1];
      end else if (state_d == S_SHIFT) begin
         mosi_d = frame_q[SHIFT_LAST - cnt_d];
      end
   end

   // State and output registers; async reset forces an idle, deselected bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         frame_q    <= '0;
         rx_q       <= '0;
         rd_data_q  <= '0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: one instance with RD_WAIT=3, one with RD_WAIT=0.
module tb_spi_master_ctrl;

   logic       clk;
   logic       clk_en;
   logic       rst;

   logic       start3, start0;
   logic [9:0] cmd3, cmd0;
   logic       miso3, miso0;
   logic       busy3, busy0, done3, done0, rdv3, rdv0, ss3, ss0, mosi3, mosi0;
   logic [7:0] rd3, rd0;

   int n_checks = 0;
   int n_err    = 0;

   // per-cycle traces of the most recent frame (cycle 1 = first cycle after the accepting edge)
   logic       tr_ss   [1:40];
   logic       tr_mosi [1:40];
   logic       tr_done [1:40];
   logic       tr_rdv  [1:40];
   logic       tr_busy [1:40];
   logic [7:0] tr_rd   [1:40];

   int          m_ss_low, m_first_low, m_rise, m_refall;
   int          m_done_at, m_n_done, m_rdv_at, m_n_rdv, m_n_busy;
   logic [13:0] m_mosi;
   int          nd;

   spi_master_ctrl #(.RD_WAIT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .cmd_data(cmd3),
      .busy(busy3), .done(done3), .rd_data(rd3), .rd_valid(rdv3),
      .SS_n(ss3), .MOSI(mosi3), .MISO(miso3)
   );

   spi_master_ctrl #(.RD_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .cmd_data(cmd0),
      .busy(busy0), .done(done0), .rd_data(rd0), .rd_valid(rdv0),
      .SS_n(ss0), .MOSI(mosi0), .MISO(miso0)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // MOSI over cycles 1..14: SELECT 0, CMD frame[9], ten frame bits MSB first, HOLD 0, END 0
   function automatic logic [13:0] exp_mosi(input logic [9:0] f);
      return {1'b0, f[9], f, 2'b00};
   endfunction

   // Launch one frame on the selected DUT (which=0: RD_WAIT=3, which=1: RD_WAIT=0) and trace ncyc cycles
   task automatic run(input bit which, input logic [9:0] cmd, input logic [7:0] mbyte, input int mfrom,
                      input int ncyc, input int inj_at, input logic [9:0] inj_cmd, input int hold_from);
      logic       s_v;
      logic [9:0] c_v;
      logic       m_v;
      if (which) begin start0 = 1'b1; cmd0 = cmd; end
      else       begin start3 = 1'b1; cmd3 = cmd; end
      @(posedge clk); #1;
      for (int c = 1; c <= ncyc; c++) begin
         s_v = (c == inj_at) || (hold_from > 0 && c >= hold_from);
         c_v = (c == inj_at) ? inj_cmd : cmd;
         m_v = (c >= mfrom && c < mfrom + 8) ? mbyte[3'(7 - (c - mfrom))] : 1'b0;
         if (which) begin start0 = s_v; cmd0 = c_v; miso0 = m_v; end
         else       begin start3 = s_v; cmd3 = c_v; miso3 = m_v; end
         tr_ss[c]   = which ? ss0   : ss3;
         tr_mosi[c] = which ? mosi0 : mosi3;
         tr_done[c] = which ? done0 : done3;
         tr_rdv[c]  = which ? rdv0  : rdv3;
         tr_busy[c] = which ? busy0 : busy3;
         tr_rd[c]   = which ? rd0   : rd3;
         @(posedge clk); #1;
      end
      start0 = 1'b0; start3 = 1'b0; miso0 = 1'b0; miso3 = 1'b0;

      m_ss_low = 0; m_first_low = -1; m_rise = -1; m_refall = -1;
      m_done_at = -1; m_n_done = 0; m_rdv_at = -1; m_n_rdv = 0; m_n_busy = 0; m_mosi = '0;
      for (int c = 1; c <= ncyc; c++) begin
         if (tr_ss[c] === 1'b0) begin
            if (m_rise < 0) begin
               m_ss_low++;
               if (m_first_low < 0) m_first_low = c;
            end else if (m_refall < 0) begin
               m_refall = c;
            end
         end else if (m_first_low >= 0 && m_rise < 0) begin
            m_rise = c;
         end
         if (tr_done[c] === 1'b1) begin
            m_n_done++;
            if (m_done_at < 0) m_done_at = c;
         end
         if (tr_rdv[c] === 1'b1) begin
            m_n_rdv++;
            if (m_rdv_at < 0) m_rdv_at = c;
         end
         if (tr_busy[c] === 1'b1) m_n_busy++;
         if (c <= 14) m_mosi[4'(14 - c)] = tr_mosi[c];
      end
   endtask

   initial begin
      clk_en = 1'b0;
      rst = 1'b0;
      start3 = 1'b0; start0 = 1'b0;
      cmd3 = '0; cmd0 = '0;
      miso3 = 1'b0; miso0 = 1'b0;

      // async reset with no clock running
      #3 rst = 1'b1;
      #1;
      chk("rst_ss_n",     32'(ss3),   32'd1);
      chk("rst_mosi",     32'(mosi3), 32'd0);
      chk("rst_busy",     32'(busy3), 32'd0);
      chk("rst_done",     32'(done3), 32'd0);
      chk("rst_rd_valid", 32'(rdv3),  32'd0);
      chk("rst_rd_data",  32'(rd3),   32'd0);
      chk("rst_dut0_bundle", 32'({ss0, mosi0, busy0, done0, rdv0, rd0}), 32'({1'b1, 12'h000}));
      #5 rst = 1'b0;
      clk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // write-address 0x0A5
      run(1'b0, 10'h0A5, 8'h00, 99, 16, 0, 10'h000, 0);
      chk("wa_mosi",      32'(m_mosi),      32'(exp_mosi(10'h0A5)));
      chk("wa_ss_low",    32'(m_ss_low),    32'd13);
      chk("wa_first_low", 32'(m_first_low), 32'd1);
      chk("wa_ss_rise",   32'(m_rise),      32'd14);
      chk("wa_done_at",   32'(m_done_at),   32'd14);
      chk("wa_n_done",    32'(m_n_done),    32'd1);
      chk("wa_n_rdv",     32'(m_n_rdv),     32'd0);
      chk("wa_n_busy",    32'(m_n_busy),    32'd14);

      // read-data 0x3FF, RD_WAIT=3, slave returns 0xC3 from cycle 17
      run(1'b0, 10'h3FF, 8'hC3, 17, 28, 0, 10'h000, 0);
      chk("rd3_mosi",     32'(m_mosi),      32'(exp_mosi(10'h3FF)));
      chk("rd3_ss_low",   32'(m_ss_low),    32'd24);
      chk("rd3_ss_rise",  32'(m_rise),      32'd25);
      chk("rd3_done_at",  32'(m_done_at),   32'd25);
      chk("rd3_rdv_at",   32'(m_rdv_at),    32'd25);
      chk("rd3_n_done",   32'(m_n_done),    32'd1);
      chk("rd3_n_rdv",    32'(m_n_rdv),     32'd1);
      chk("rd3_data_pre", 32'(tr_rd[24]),   32'h00);
      chk("rd3_data",     32'(tr_rd[25]),   32'hC3);
      chk("rd3_data_hold",32'(tr_rd[28]),   32'hC3);

      // read-address 0x2AA: write-like timing, rd_data untouched
      run(1'b0, 10'h2AA, 8'hFF, 14, 16, 0, 10'h000, 0);
      chk("ra_mosi",      32'(m_mosi),      32'(exp_mosi(10'h2AA)));
      chk("ra_ss_low",    32'(m_ss_low),    32'd13);
      chk("ra_done_at",   32'(m_done_at),   32'd14);
      chk("ra_n_rdv",     32'(m_n_rdv),     32'd0);
      chk("ra_rd_data",   32'(tr_rd[16]),   32'hC3);

      // read-data 0x3FF on the RD_WAIT=0 instance, slave returns 0x5A from cycle 14
      run(1'b1, 10'h3FF, 8'h5A, 14, 24, 0, 10'h000, 0);
      chk("rd0_ss_low",   32'(m_ss_low),    32'd21);
      chk("rd0_ss_rise",  32'(m_rise),      32'd22);
      chk("rd0_done_at",  32'(m_done_at),   32'd22);
      chk("rd0_rdv_at",   32'(m_rdv_at),    32'd22);
      chk("rd0_data",     32'(tr_rd[22]),   32'h5A);

      // busy rejection (0x155 during SHIFT) then start held high for back-to-back
      run(1'b0, 10'h0A5, 8'h00, 99, 20, 5, 10'h155, 8);
      chk("b2b_mosi",     32'(m_mosi),      32'(exp_mosi(10'h0A5)));
      chk("b2b_ss_low",   32'(m_ss_low),    32'd13);
      chk("b2b_n_done",   32'(m_n_done),    32'd1);
      chk("b2b_ss_rise",  32'(m_rise),      32'd14);
      chk("b2b_ss_refall",32'(m_refall),    32'd16);
      repeat (15) @(posedge clk);
      #1;
      chk("b2b_idle",     32'(busy3),       32'd0);

      // reset during SHIFT i=5 of a read-data frame
      run(1'b0, 10'h3FF, 8'h00, 99, 7, 0, 10'h000, 0);
      chk("mr_pre_ss",    32'(ss3),         32'd0);
      #2 rst = 1'b1;
      #1;
      chk("mr_ss_n",      32'(ss3),         32'd1);
      chk("mr_busy",      32'(busy3),       32'd0);
      chk("mr_mosi",      32'(mosi3),       32'd0);
      chk("mr_rd_data",   32'(rd3),         32'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done3 === 1'b1 || rdv3 === 1'b1) nd++;
      end
      chk("mr_no_done",   32'(nd),          32'd0);

      // write-data 0x1FF after reset release
      run(1'b0, 10'h1FF, 8'h00, 99, 16, 0, 10'h000, 0);
      chk("wd_mosi",      32'(m_mosi),      32'(exp_mosi(10'h1FF)));
      chk("wd_ss_low",    32'(m_ss_low),    32'd13);
      chk("wd_done_at",   32'(m_done_at),   32'd14);
      chk("wd_n_rdv",     32'(m_n_rdv),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
